// File: rtl/nf10_1g_rx_arbiter_pkg.sv
// Shared definitions for the 1G rx arbiter: FSM encoding, port-id width and
// the round-robin pick used when both rx ports request at once.
package nf10_1g_rx_arbiter_pkg;

    localparam int PORT_ID_W  = 1;
    // Sideband carried with each beat: tlast, tuser (port id), err.
    localparam int SIDEBAND_W = 2 + PORT_ID_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } arb_state_e;

    function automatic logic [PORT_ID_W-1:0] rr_pick(
        input logic v0,
        input logic v1,
        input logic [PORT_ID_W-1:0] last_grant
    );
        if (v0 && v1) begin
            rr_pick = ~last_grant;
        end else if (v1) begin
            rr_pick = 1'b1;
        end else begin
            rr_pick = 1'b0;
        end
    endfunction

endpackage

// File: rtl/nf10_axis_skid_buf.sv
// Two-entry AXI-Stream register slice: registered outputs and a registered
// upstream ready, so downstream ready never reaches the upstream combinationally.
module nf10_axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i
);

    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         accept_s, pop_s;

    assign accept_s  = s_valid_i && !skid_vld_q;
    assign pop_s     = main_vld_q && m_ready_i;
    assign s_ready_o = !skid_vld_q;
    assign m_data_o  = main_q;
    assign m_valid_o = main_vld_q;

    // Main slot refills from skid first to keep beat order; skid only fills on a stall.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || pop_s) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept_s) begin
                main_d     = s_data_i;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept_s) begin
            skid_d     = s_data_i;
            skid_vld_d = 1'b1;
        end else begin
            skid_vld_d = skid_vld_q;
        end
    end

    // Slice state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

endmodule

// File: rtl/nf10_1g_rx_arbiter.sv
// Packet-granular round-robin merge of the two 1G rx streams onto one stream,
// tagging each packet with its source port and counting completed packets per port.
module nf10_1g_rx_arbiter
    import nf10_1g_rx_arbiter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 8,
    parameter int C_CNT_WIDTH       = 32
) (
    input  logic                           axi_aclk,
    input  logic                           axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_0,
    input  logic                           s_axis_tvalid_0,
    output logic                           s_axis_tready_0,
    input  logic                           s_axis_tlast_0,
    input  logic                           s_axis_err_0,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_1,
    input  logic                           s_axis_tvalid_1,
    output logic                           s_axis_tready_1,
    input  logic                           s_axis_tlast_1,
    input  logic                           s_axis_err_1,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           m_axis_err,
    output logic [C_CNT_WIDTH-1:0]         pkt_cnt_0,
    output logic [C_CNT_WIDTH-1:0]         pkt_cnt_1
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int PW = DW + SW + SIDEBAND_W;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    arb_state_e           state_q;
    logic [PORT_ID_W-1:0] grant_q, last_grant_q;

    logic [DW-1:0] sel_data_s;
    logic [SW-1:0] sel_strb_s;
    logic          sel_valid_s, sel_last_s, sel_err_s;
    logic          in_pass_s, buf_valid_s, buf_ready_s, accept_s, out_hs_s;
    logic [PW-1:0] in_payload_s, out_payload_s;

    // Input mux: the granted port drives the slice for the whole packet.
    always_comb begin
        sel_data_s  = s_axis_tdata_0;
        sel_strb_s  = s_axis_tstrb_0;
        sel_valid_s = s_axis_tvalid_0;
        sel_last_s  = s_axis_tlast_0;
        sel_err_s   = s_axis_err_0;
        if (grant_q == 1'b1) begin
            sel_data_s  = s_axis_tdata_1;
            sel_strb_s  = s_axis_tstrb_1;
            sel_valid_s = s_axis_tvalid_1;
            sel_last_s  = s_axis_tlast_1;
            sel_err_s   = s_axis_err_1;
        end else begin
            sel_data_s  = s_axis_tdata_0;
            sel_strb_s  = s_axis_tstrb_0;
            sel_valid_s = s_axis_tvalid_0;
            sel_last_s  = s_axis_tlast_0;
            sel_err_s   = s_axis_err_0;
        end
    end

    assign in_pass_s       = (state_q == ST_PASS);
    assign buf_valid_s     = in_pass_s && sel_valid_s;
    assign accept_s        = buf_valid_s && buf_ready_s;
    assign s_axis_tready_0 = in_pass_s && (grant_q == 1'b0) && buf_ready_s;
    assign s_axis_tready_1 = in_pass_s && (grant_q == 1'b1) && buf_ready_s;
    assign in_payload_s    = {sel_data_s, sel_strb_s, sel_last_s, grant_q, sel_err_s && sel_last_s};

    // Grant FSM: pick a port in IDLE, hold it until its tlast beat is accepted.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid_0 || s_axis_tvalid_1) begin
                        grant_q      <= rr_pick(s_axis_tvalid_0, s_axis_tvalid_1, last_grant_q);
                        last_grant_q <= rr_pick(s_axis_tvalid_0, s_axis_tvalid_1, last_grant_q);
                        state_q      <= ST_PASS;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PASS: begin
                    if (accept_s && sel_last_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_PASS;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    nf10_axis_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk_i    (axi_aclk),
        .rst_n_i  (axi_resetn),
        .s_data_i (in_payload_s),
        .s_valid_i(buf_valid_s),
        .s_ready_o(buf_ready_s),
        .m_data_o (out_payload_s),
        .m_valid_o(m_axis_tvalid),
        .m_ready_i(m_axis_tready)
    );

    assign m_axis_tdata = out_payload_s[PW-1 -: DW];
    assign m_axis_tstrb = out_payload_s[SIDEBAND_W +: SW];
    assign m_axis_tlast = out_payload_s[2];
    assign m_axis_tuser = out_payload_s[1];
    assign m_axis_err   = out_payload_s[0];
    assign out_hs_s     = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Per-port packet counters, bumped when a packet's tlast leaves the block.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else if (out_hs_s) begin
            if (m_axis_tuser) begin
                pkt_cnt_1 <= pkt_cnt_1 + CNT_ONE;
            end else begin
                pkt_cnt_0 <= pkt_cnt_0 + CNT_ONE;
            end
        end else begin
            pkt_cnt_0 <= pkt_cnt_0;
            pkt_cnt_1 <= pkt_cnt_1;
        end
    end

endmodule

// File: tb/tb_nf10_1g_rx_arbiter.sv
// Directed self-checking bench for nf10_1g_rx_arbiter (4-bit counters to reach wrap).
module tb_nf10_1g_rx_arbiter;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata [2];
    logic [0:0]    s_tstrb [2];
    logic          s_tvalid[2];
    logic          s_tlast [2];
    logic          s_err   [2];
    logic          s_tready_0, s_tready_1;
    logic [DW-1:0] m_tdata;
    logic [0:0]    m_tstrb;
    logic          m_tvalid, m_tready, m_tlast, m_tuser, m_err;
    logic [CW-1:0] pkt_cnt_0, pkt_cnt_1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_acc[2];

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       e;
        int         c;
    } beat_t;
    beat_t mon_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nf10_1g_rx_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tvalid_0(s_tvalid[0]),
        .s_axis_tready_0(s_tready_0), .s_axis_tlast_0(s_tlast[0]), .s_axis_err_0(s_err[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tvalid_1(s_tvalid[1]),
        .s_axis_tready_1(s_tready_1), .s_axis_tlast_1(s_tlast[1]), .s_axis_err_1(s_err[1]),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_err(m_err), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
    );

    // Output monitor: records every accepted output beat with its cycle number.
    always @(negedge clk) begin
        beat_t bt;
        if (rst_n && m_tvalid && m_tready) begin
            bt.d = m_tdata; bt.l = m_tlast; bt.u = m_tuser; bt.e = m_err; bt.c = cyc;
            mon_q.push_back(bt);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        m_tready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            s_tvalid[p] = 1'b0; s_tdata[p] = 8'h00; s_tstrb[p] = 1'b0;
            s_tlast[p] = 1'b0; s_err[p] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_q.delete();
    endtask

    // Sends one packet; with e=1 the err flag is held high on every beat.
    task automatic drive_pkt(input int p, input int nb, input logic [7:0] base, input logic e);
        int guard;
        logic rdy;
        for (int b = 0; b < nb; b++) begin
            s_tvalid[p] = 1'b1; s_tdata[p] = base + 8'(b); s_tstrb[p] = 1'b1;
            s_tlast[p] = (b == nb - 1); s_err[p] = e;
            guard = 0;
            forever begin
                @(negedge clk);
                rdy = (p == 0) ? s_tready_0 : s_tready_1;
                if (rdy) begin
                    if (b == 0) first_acc[p] = cyc;
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                guard++;
                if (guard > 300) begin
                    total++; bad++;
                    $display("FAIL drive_timeout port=%0d beat=%0d got no tready, required tready", p, b);
                    s_tvalid[p] = 1'b0; s_tlast[p] = 1'b0; s_err[p] = 1'b0;
                    return;
                end
            end
        end
        s_tvalid[p] = 1'b0; s_tlast[p] = 1'b0; s_err[p] = 1'b0;
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int guard = 0;
        while (mon_q.size() < n && guard < 800) begin
            @(negedge clk); guard++;
        end
        ok = (mon_q.size() >= n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        m_tready = 1'b1;
        s_tvalid[0] = 1'b1; s_tdata[0] = 8'h11; s_tstrb[0] = 1'b1; s_tlast[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL rst_midpkt_valid got=%b want=1", m_tvalid); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser, m_err, s_tready_0, s_tready_1} !== 15'h0) begin
            bad++; $display("FAIL rst_outputs got v=%b d=%h s=%b l=%b u=%b e=%b r0=%b r1=%b want all 0",
                m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser, m_err, s_tready_0, s_tready_1);
        end
        total++;
        if (pkt_cnt_0 !== 4'd0 || pkt_cnt_1 !== 4'd0) begin
            bad++; $display("FAIL rst_counters got %0d/%0d want 0/0", pkt_cnt_0, pkt_cnt_1);
        end
        s_tvalid[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        mon_q.delete();
        drive_pkt(0, 3, 8'hA0, 1'b0);
        wait_beats(3, ok);
        total++; if (!ok || mon_q.size() != 3) begin bad++; $display("FAIL rst_pkt_beats got=%0d want=3", mon_q.size()); end
        for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].d !== 8'hA0 + 8'(i) || mon_q[i].u !== 1'b0 || mon_q[i].l !== (i == 2)) begin
                bad++; $display("FAIL rst_pkt_beat%0d got d=%h u=%b l=%b want d=%h u=0 l=%0d",
                    i, mon_q[i].d, mon_q[i].u, mon_q[i].l, 8'hA0 + 8'(i), (i == 2));
            end
        end
        if (mon_q.size() > 0) begin
            total++;
            if (mon_q[0].c != first_acc[0] + 1) begin
                bad++; $display("FAIL rst_latency got=%0d want=1", mon_q[0].c - first_acc[0]);
            end
        end
        total++; if (pkt_cnt_0 !== 4'd1) begin bad++; $display("FAIL rst_pkt_cnt0 got=%0d want=1", pkt_cnt_0); end
    endtask

    task automatic test_contention();
        bit ok;
        logic [7:0] bases[4] = '{8'h00, 8'h10, 8'h20, 8'h30};
        do_reset();
        m_tready = 1'b1;
        fork
            begin drive_pkt(0, 4, 8'h00, 1'b0); drive_pkt(0, 4, 8'h20, 1'b0); end
            begin drive_pkt(1, 4, 8'h10, 1'b0); drive_pkt(1, 4, 8'h30, 1'b0); end
        join
        wait_beats(16, ok);
        total++; if (!ok || mon_q.size() != 16) begin bad++; $display("FAIL cont_beats got=%0d want=16", mon_q.size()); end
        for (int i = 0; i < 16 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].d !== bases[i/4] + 8'(i%4) || mon_q[i].u !== 1'((i/4)%2) || mon_q[i].l !== (i%4 == 3)) begin
                bad++; $display("FAIL cont_beat%0d got d=%h u=%b l=%b want d=%h u=%0d l=%0d",
                    i, mon_q[i].d, mon_q[i].u, mon_q[i].l, bases[i/4] + 8'(i%4), (i/4)%2, (i%4 == 3));
            end
            if (i > 0) begin
                total++;
                if (mon_q[i].c - mon_q[i-1].c != ((i%4 == 0) ? 2 : 1)) begin
                    bad++; $display("FAIL cont_gap%0d got=%0d want=%0d", i, mon_q[i].c - mon_q[i-1].c, (i%4 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] exp_d[13];
        logic       exp_u[13];
        logic       exp_l[13];
        for (int i = 0; i < 5; i++) begin exp_d[i] = 8'h40 + 8'(i); exp_u[i] = 1'b0; exp_l[i] = (i == 4); end
        for (int i = 0; i < 3; i++) begin exp_d[5+i] = 8'h60 + 8'(i); exp_u[5+i] = 1'b1; exp_l[5+i] = (i == 2); end
        for (int i = 0; i < 5; i++) begin exp_d[8+i] = 8'h50 + 8'(i); exp_u[8+i] = 1'b0; exp_l[8+i] = (i == 4); end
        do_reset();
        fork
            begin drive_pkt(0, 5, 8'h40, 1'b0); drive_pkt(0, 5, 8'h50, 1'b0); end
            drive_pkt(1, 3, 8'h60, 1'b0);
            begin : toggler
                logic        prev_stall;
                logic [12:0] prev_vec, cur_vec;
                int          g;
                prev_stall = 1'b0; prev_vec = '0; g = 0;
                while (mon_q.size() < 13 && g < 600) begin
                    @(posedge clk); #1;
                    m_tready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cur_vec = {m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser, m_err};
                    if (prev_stall) begin
                        total++;
                        if (cur_vec !== prev_vec) begin
                            bad++; $display("FAIL bp_stable got=%h want=%h", cur_vec, prev_vec);
                        end
                    end
                    prev_stall = m_tvalid && !m_tready;
                    prev_vec = cur_vec;
                    g++;
                end
                m_tready = 1'b1;
            end
        join
        wait_beats(13, ok);
        total++; if (!ok || mon_q.size() != 13) begin bad++; $display("FAIL bp_beats got=%0d want=13", mon_q.size()); end
        for (int i = 0; i < 13 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].d !== exp_d[i] || mon_q[i].u !== exp_u[i] || mon_q[i].l !== exp_l[i]) begin
                bad++; $display("FAIL bp_beat%0d got d=%h u=%b l=%b want d=%h u=%b l=%b",
                    i, mon_q[i].d, mon_q[i].u, mon_q[i].l, exp_d[i], exp_u[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_err_flag();
        bit ok;
        do_reset();
        m_tready = 1'b1;
        drive_pkt(1, 3, 8'hC0, 1'b1);
        wait_beats(3, ok);
        total++; if (!ok || mon_q.size() != 3) begin bad++; $display("FAIL err_beats got=%0d want=3", mon_q.size()); end
        for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].e !== (i == 2) || mon_q[i].u !== 1'b1 || mon_q[i].d !== 8'hC0 + 8'(i)) begin
                bad++; $display("FAIL err_beat%0d got e=%b u=%b d=%h want e=%0d u=1 d=%h",
                    i, mon_q[i].e, mon_q[i].u, mon_q[i].d, (i == 2), 8'hC0 + 8'(i));
            end
        end
        total++;
        if (pkt_cnt_1 !== 4'd1 || pkt_cnt_0 !== 4'd0) begin
            bad++; $display("FAIL err_pkt_cnt got %0d/%0d want 0/1", pkt_cnt_0, pkt_cnt_1);
        end
    endtask

    task automatic test_single_beat();
        bit ok;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) drive_pkt(0, 1, 8'h70 + 8'(i), 1'b0);
        wait_beats(10, ok);
        total++; if (!ok || mon_q.size() != 10) begin bad++; $display("FAIL sb_beats got=%0d want=10", mon_q.size()); end
        for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i].d !== 8'h70 + 8'(i) || mon_q[i].l !== 1'b1 || mon_q[i].u !== 1'b0) begin
                bad++; $display("FAIL sb_beat%0d got d=%h l=%b u=%b want d=%h l=1 u=0",
                    i, mon_q[i].d, mon_q[i].l, mon_q[i].u, 8'h70 + 8'(i));
            end
            if (i > 0) begin
                total++;
                if (mon_q[i].c - mon_q[i-1].c != 2) begin
                    bad++; $display("FAIL sb_gap%0d got=%0d want=2", i, mon_q[i].c - mon_q[i-1].c);
                end
            end
        end
        total++; if (pkt_cnt_0 !== 4'd10) begin bad++; $display("FAIL sb_pkt_cnt0 got=%0d want=10", pkt_cnt_0); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) drive_pkt(1, 1, 8'(i), 1'b0);
        wait_beats(16, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_beats16 got=%0d want=16", mon_q.size()); end
        total++; if (pkt_cnt_1 !== 4'd0) begin bad++; $display("FAIL wrap_cnt16 got=%0d want=0", pkt_cnt_1); end
        drive_pkt(1, 1, 8'hEE, 1'b0);
        wait_beats(17, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_beats17 got=%0d want=17", mon_q.size()); end
        total++; if (pkt_cnt_1 !== 4'd1) begin bad++; $display("FAIL wrap_cnt17 got=%0d want=1", pkt_cnt_1); end
        total++; if (pkt_cnt_0 !== 4'd0) begin bad++; $display("FAIL wrap_cnt0 got=%0d want=0", pkt_cnt_0); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_backpressure();
        test_err_flag();
        test_single_beat();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
